// File: rtl/mc_controller_if.sv
// mc_controller_if: control-unit <-> datapath signal bundle.
// master = control unit, slave = datapath side.
interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write,
    output result_src, alu_src_a, alu_src_b, imm_src,
    output reg_write, alu_control, illegal_op, state
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write,
    input  result_src, alu_src_a, alu_src_b, imm_src,
    input  reg_write, alu_control, illegal_op, state
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control unit.
// Moore FSM with memory-ready wait states.
module mc_controller (
  input logic           clk,
  input logic           reset_n,
  mc_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t state_q, state_d;

  logic is_mem, is_r, is_i, is_jal, is_beq;
  logic pc_update, branch;
  logic [1:0] alu_op;

  assign is_mem = (bus.op == 7'b0000011) |
                  (bus.op == 7'b0100011);
  assign is_r   = bus.op == 7'b0110011;
  assign is_i   = bus.op == 7'b0010011;
  assign is_jal = bus.op == 7'b1101111;
  assign is_beq = bus.op == 7'b1100011;

  // Next-state selection; stray codes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:  state_d = S_MEMADR;
          is_r:    state_d = S_EXECR;
          is_i:    state_d = S_EXECI;
          is_jal:  state_d = S_JAL;
          is_beq:  state_d = S_BEQ;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:
        state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL:
        state_d = S_ALUWB;
      default:
        state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Moore control outputs per state.
  always_comb begin
    pc_update      = 1'b0;
    branch         = 1'b0;
    alu_op         = 2'b00;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.reg_write  = 1'b0;
    bus.illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready;
        pc_update      = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_a  = 2'b01;
        bus.alu_src_b  = 2'b01;
        bus.illegal_op = ~(is_mem | is_r | is_i |
                           is_jal | is_beq);
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      S_MEMREAD:
        bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        alu_op        = 2'b10;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        alu_op        = 2'b10;
      end
      S_ALUWB:
        bus.reg_write = 1'b1;
      S_JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_update     = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a = 2'b10;
        alu_op        = 2'b01;
        branch        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write = pc_update | (branch & bus.zero);
  assign bus.state    = state_q;

  // ALU operation decode; only R-type subtracts on funct7b5.
  always_comb begin
    bus.alu_control = 3'b000;
    case (alu_op)
      2'b01: bus.alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:
            bus.alu_control =
              (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_control = 3'b101;
          3'b110:  bus.alu_control = 3'b011;
          3'b111:  bus.alu_control = 3'b010;
          default: bus.alu_control = 3'b000;
        endcase
      end
      default: bus.alu_control = 3'b000;
    endcase
  end

  // Immediate format from opcode, independent of state.
  always_comb begin
    bus.imm_src = 2'b00;
    unique case (1'b1)
      bus.op == 7'b0100011: bus.imm_src = 2'b01;
      is_beq:               bus.imm_src = 2'b10;
      is_jal:               bus.imm_src = 2'b11;
      default:              bus.imm_src = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random + directed bench for mc_controller.
// Reference model walks per-instruction state paths.
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  mc_controller_if ifc ();

  mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.master)
  );

  always #5 clk = ~clk;

  int path[$];
  logic mr_q[$];
  int zero_force = -1;
  bit rand_mr = 1'b0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  function automatic bit legal(logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
  endfunction

  // Sequence of states an instruction visits, ignoring waits.
  function automatic void build_path(logic [6:0] o);
    path = '{0, 1};
    case (o)
      OP_LW:  begin path.push_back(2); path.push_back(3);
                    path.push_back(4); end
      OP_SW:  begin path.push_back(2); path.push_back(5); end
      OP_R:   begin path.push_back(6); path.push_back(7); end
      OP_I:   begin path.push_back(8); path.push_back(7); end
      OP_JAL: begin path.push_back(9); path.push_back(7); end
      OP_BEQ: path.push_back(10);
      default: ;
    endcase
  endfunction

  // Expected output bundle for a state and the current inputs.
  function automatic logic [16:0] exp_out(
    int s, logic [6:0] o, logic [2:0] f3,
    logic f7, logic z, logic mr);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 0; a = 0; b = 0; alu = 0;
    imm = (o == OP_SW) ? 2'd1 :
          (o == OP_BEQ) ? 2'd2 :
          (o == OP_JAL) ? 2'd3 : 2'd0;
    case (s)
      0:  begin b = 2; rs = 2; irw = mr; pcw = mr; end
      1:  begin a = 1; b = 1; ill = !legal(o); end
      2:  begin a = 2; b = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6, 8: begin
        a = 2;
        if (s == 8) b = 1;
        case (f3)
          3'd0: alu = (f7 && o[5]) ? 3'd1 : 3'd0;
          3'd2: alu = 3'd5;
          3'd6: alu = 3'd3;
          3'd7: alu = 3'd2;
          default: alu = 3'd0;
        endcase
      end
      7:  rw = 1;
      9:  begin a = 1; b = 2; pcw = 1; end
      10: begin a = 2; alu = 3'd1; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill};
  endfunction

  task automatic do_check(input int s);
    logic [16:0] got, exp;
    got = {ifc.pc_write, ifc.adr_src, ifc.mem_write,
           ifc.ir_write, ifc.result_src, ifc.alu_src_a,
           ifc.alu_src_b, ifc.imm_src, ifc.reg_write,
           ifc.alu_control, ifc.illegal_op};
    exp = exp_out(s, ifc.op, ifc.funct3, ifc.funct7b5,
                  ifc.zero, ifc.mem_ready);
    checks++;
    assert (ifc.state === 4'(s)) else begin
      errors++;
      $error("FAIL state got %0d exp %0d op %b",
             ifc.state, s, ifc.op);
    end
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL outputs st %0d op %b got %b exp %b",
             s, ifc.op, got, exp);
    end
  endtask

  function automatic logic next_mr();
    if (mr_q.size() > 0) return mr_q.pop_front();
    if (rand_mr) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // Called just after a rising edge with state at FETCH.
  task automatic run_instr(input logic [6:0] o,
                           input logic [2:0] f3,
                           input logic f7);
    int idx, guard, s;
    logic mr;
    build_path(o);
    ifc.op = o;
    ifc.funct3 = f3;
    ifc.funct7b5 = f7;
    idx = 0;
    guard = 0;
    while (idx < path.size() && guard < 64) begin
      mr = next_mr();
      ifc.mem_ready = mr;
      ifc.zero = (zero_force < 0) ? 1'($urandom_range(0, 1))
                                  : 1'(zero_force);
      @(negedge clk);
      s = path[idx];
      do_check(s);
      @(posedge clk);
      #1;
      if (!(s inside {0, 3, 5}) || mr) idx++;
      guard++;
    end
    checks++;
    assert (idx >= path.size()) else begin
      errors++;
      $error("FAIL timeout op %b idx %0d", o, idx);
    end
  endtask

  initial begin
    logic [6:0] ops [7];
    logic [6:0] bad [5];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, 7'h00};
    bad = '{7'h00, 7'h37, 7'h17, 7'h67, 7'h73};
    ifc.op = OP_LW;
    ifc.funct3 = 3'd0;
    ifc.funct7b5 = 1'b0;
    ifc.zero = 1'b0;
    ifc.mem_ready = 1'b0;
    #2;
    do_check(0);
    ifc.mem_ready = 1'b1;
    #1;
    do_check(0);
    ifc.mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // fetch stall, then lw
    mr_q = '{1'b0, 1'b0, 1'b1};
    run_instr(OP_LW, 3'd2, 1'b0);
    // sw with two memory wait cycles
    mr_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_instr(OP_SW, 3'd2, 1'b0);
    run_instr(OP_R, 3'd0, 1'b1);
    run_instr(OP_R, 3'd0, 1'b0);
    run_instr(OP_I, 3'd0, 1'b1);
    run_instr(OP_R, 3'd2, 1'b0);
    run_instr(OP_R, 3'd6, 1'b0);
    run_instr(OP_R, 3'd7, 1'b0);
    zero_force = 1;
    run_instr(OP_BEQ, 3'd0, 1'b0);
    zero_force = 0;
    run_instr(OP_BEQ, 3'd0, 1'b0);
    zero_force = -1;
    run_instr(OP_JAL, 3'd0, 1'b0);
    run_instr(7'h00, 3'd0, 1'b0);
    // reset pulse while lw waits in MEMREAD
    ifc.op = OP_LW;
    ifc.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      do_check(c);
      @(posedge clk);
      #1;
    end
    ifc.mem_ready = 1'b0;
    @(negedge clk);
    do_check(3);
    #1 reset_n = 1'b0;
    #1 do_check(0);
    @(posedge clk);
    #1 do_check(0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 do_check(0);
    run_instr(OP_R, 3'd0, 1'b1);
    // random instruction mix with random memory waits
    rand_mr = 1'b1;
    for (int n = 0; n < 60; n++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 6)];
      if (o == 7'h00) o = bad[$urandom_range(0, 4)];
      run_instr(o, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V core. It sequences the shared datapath (one memory, one ALU, PC/IR/ALUOut registers) through a Moore state machine of 11 states. It decodes the ALU operation using the same ALUControl encoding as the datapath ALU. A ready handshake on the unified memory lets fetch, load and store stretch over wait states.

## Interface
- No parameters.
- `clk` in 1 — single clock; all state updates on rising edge.
- `reset_n` in 1 — asynchronous, active-low reset; forces state to FETCH.
- `op` in 7 — instr[6:0], from IR.
- `funct3` in 3 — instr[14:12].
- `funct7b5` in 1 — instr[30].
- `zero` in 1 — ALU zero flag.
- `mem_ready` in 1 — memory completes current access this cycle.
- `pc_write` out 1 — PC load enable.
- `adr_src` out 1 — 0: PC, 1: ALUOut as memory address.
- `mem_write` out 1 — memory write strobe.
- `ir_write` out 1 — IR/OldPC load enable.
- `result_src` out 2 — 00 ALUOut, 01 Data, 10 ALUResult.
- `alu_src_a` out 2 — 00 PC, 01 OldPC, 10 RD1.
- `alu_src_b` out 2 — 00 WD(RD2), 01 ImmExt, 10 constant 4.
- `imm_src` out 2 — 00 I, 01 S, 10 B, 11 J.
- `reg_write` out 1 — register-file write enable.
- `alu_control` out 3 — 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal_op` out 1 — one-cycle pulse in DECODE for an unsupported opcode.
- `state` out 4 — current state code (debug).

## Operation
- State codes:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB, 5 MEMWRITE.
  - 6 EXECUTER, 7 ALUWB, 8 EXECUTEI, 9 JAL, 10 BEQ.
  - Codes 11–15 are unreachable; if entered, go to FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready=1, else stay.
  - DECODE by op:
    - 0000011/0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other op → FETCH, with illegal_op=1.
  - MEMADR→MEMREAD if op[5]=0, →MEMWRITE if op[5]=1.
  - MEMREAD→MEMWB when mem_ready=1, else stay.
  - MEMWB→FETCH.
  - MEMWRITE→FETCH when mem_ready=1, else stay.
  - EXECUTER, EXECUTEI, JAL→ALUWB.
  - ALUWB→FETCH.
  - BEQ→FETCH.
- Moore outputs per state; anything unlisted is 0/00:
  - FETCH: alu_src_b=10, result_src=10; ir_write=mem_ready, pc_update=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1, held until mem_ready.
  - EXECUTER: alu_src_a=10, alu_op=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
  - BEQ: alu_src_a=10, alu_op=01, branch=1.
- pc_write = pc_update | (branch & zero).
- ALU decode:
  - alu_op 00 → add; alu_op 01 → sub.
  - alu_op 10, by funct3:
    - 000: sub if funct7b5&op[5], else add
    - 010: slt
    - 110: or
    - 111: and
    - any other: add
- imm_src is combinational from op, in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - any other op → 00

## Timing
- Reset: state=FETCH immediately on reset_n falling, regardless of clk.
  - Outputs while reset is held are FETCH outputs: alu_src_b=10, result_src=10, all others 0.
  - ir_write and pc_write equal mem_ready.
- Reset asserted mid-instruction aborts the instruction; no further reg_write or mem_write is issued.
- Cycle counts with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
  - Each memory wait cycle adds 1.
- All outputs are combinational from state, op, funct3, funct7b5, zero and mem_ready. There are no registered outputs besides state.
- pc_write in BEQ follows zero within the same cycle.

## Test plan
- lw, mem_ready=1: states 0,1,2,3,4,0. reg_write=1 only in state 4; result_src=01 there.
- sw with 2 wait cycles, mem_ready=0 for 2 cycles in MEMWRITE: mem_write=1 and adr_src=1 for 3 cycles, then FETCH. Zero reg_write throughout.
- R-type sub (funct3=000, funct7b5=1): alu_control=001 in EXECUTER. With funct7b5=0: 000. addi with funct7b5=1 (op[5]=0) → 000.
- beq: zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0. Both return to FETCH next cycle with imm_src=10.
- jal: states 0,1,9,7,0. pc_write=1 in JAL, imm_src=11, reg_write=1 in ALUWB. Illegal op 0000000: illegal_op=1 in DECODE, then FETCH.
- Fetch stall and reset: mem_ready=0 holds FETCH with ir_write=0. reset_n pulsed low during MEMREAD → state=0 asynchronously, and no MEMWB is reached.
